ssm_word_dispatcher: RTL and testbench

Shares one in-order stream of 128-bit bitstream words between the four substream parsers (ssm0..ssm3) of the VDC-M decoder. It buffers words from the upstream bitstream source and prefills the buffer before decode starts. Each cycle it hands consecutive words to requesting parsers in ssm-index order, and it generates the staggered decode-start pulses: ssm0 first, ssm1..3 one cycle later.

---
 rtl/ssm_word_dispatcher.sv | 154 +++++++++++++++
 tb/tb_ssm_word_dispatcher.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ssm_word_dispatcher.sv
// Word dispatcher for the four VDC-M substream parsers: buffers the bitstream,
// prefills before decode, grants in-order words to requesting parsers by index.
module ssm_word_dispatcher #(
  parameter int DW      = 128,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int PREFILL = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_dec,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          in_rdy,
  input  logic [3:0]    rd_req,
  output logic [3:0]    rd_gnt,
  output logic [DW-1:0] rd_data0,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic [DW-1:0] rd_data3,
  output logic          start_ssm0,
  output logic          start_ssm123,
  output logic          starve,
  output logic          busy,
  output logic [15:0]   word_cnt,
  output logic [AW:0]   level
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] PREFILL_C = (AW+1)'(PREFILL);

  state_t        state_r;
  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   n_s;
  logic [AW:0]   j_s;
  logic [AW:0]   k_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    gnt_s;
  logic [DW-1:0] data_s [4];
  logic          act_s;
  logic          run_s;
  logic          push_s;
  logic [16:0]   wc_sum_s;

  // flush overrides any push or grant in its cycle
  assign act_s    = (state_r != IDLE) & ~flush;
  assign run_s    = (state_r == RUN) & ~flush;
  assign in_rdy   = act_s & (count_r < DEPTH_C);
  assign push_s   = in_vld & in_rdy;
  assign rd_gnt   = gnt_s;
  assign rd_data0 = data_s[0];
  assign rd_data1 = data_s[1];
  assign rd_data2 = data_s[2];
  assign rd_data3 = data_s[3];
  assign busy     = (state_r != IDLE);
  assign level    = count_r;
  assign k_s      = j_s;
  assign wc_sum_s = {1'b0, word_cnt} + {{(16-AW){1'b0}}, k_s};

  // Grant the lowest-index requesters with consecutive words from the head
  always_comb begin
    gnt_s = 4'b0000;
    j_s   = '0;
    n_s   = '0;
    idx_s = '0;
    for (int i = 0; i < 4; i++) begin
      data_s[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      n_s = n_s + {{AW{1'b0}}, rd_req[i]};
      if (run_s && rd_req[i] && (j_s < count_r)) begin
        idx_s     = rd_ptr_r + j_s[AW-1:0];
        gnt_s[i]  = 1'b1;
        data_s[i] = mem_r[idx_s];
        j_s       = j_s + {{AW{1'b0}}, 1'b1};
      end else begin
        gnt_s[i]  = 1'b0;
      end
    end
  end

  // Word storage, written on accepted upstream words
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control FSM, buffer pointers and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      word_cnt     <= 16'h0000;
      starve       <= 1'b0;
      start_ssm0   <= 1'b0;
      start_ssm123 <= 1'b0;
    end else begin
      start_ssm0   <= 1'b0;
      start_ssm123 <= start_ssm0 & ~flush;
      case (state_r)
        IDLE: begin
          starve <= 1'b0;
          if (start_dec) begin
            state_r  <= FILL;
            word_cnt <= 16'h0000;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
          end else begin
            state_r  <= IDLE;
          end
        end
        FILL, RUN: begin
          if (flush) begin
            state_r  <= IDLE;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            starve   <= 1'b0;
          end else begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, push_s};
            rd_ptr_r <= rd_ptr_r + k_s[AW-1:0];
            count_r  <= count_r - k_s + {{AW{1'b0}}, push_s};
            word_cnt <= wc_sum_s[16] ? 16'hFFFF : wc_sum_s[15:0];
            starve   <= run_s & (k_s < n_s);
            if ((state_r == FILL) && (count_r >= PREFILL_C)) begin
              state_r    <= RUN;
              start_ssm0 <= 1'b1;
            end else begin
              state_r    <= state_r;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          rd_ptr_r <= '0;
          wr_ptr_r <= '0;
          count_r  <= '0;
          starve   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssm_word_dispatcher.sv
// Randomized bench for ssm_word_dispatcher against a queue-based model of the
// word stream, slice state and decode-start pulses.
module tb_ssm_word_dispatcher;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start_dec;
  logic         flush;
  logic         in_vld;
  logic [127:0] in_data;
  logic         in_rdy;
  logic [3:0]   rd_req;
  logic [3:0]   rd_gnt;
  logic [127:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic         start_ssm0, start_ssm123, starve, busy;
  logic [15:0]  word_cnt;
  logic [3:0]   level;

  int tests_run = 0;
  int tests_failed = 0;

  // model: 0 idle, 1 fill, 2 run
  int           ms;
  logic [127:0] q[$];
  int           m_wc;
  bit           m_starve, m_s0, m_s123;
  logic [3:0]   pend;

  ssm_word_dispatcher dut (
    .clk(clk), .rstn(rstn), .start_dec(start_dec), .flush(flush),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .rd_req(rd_req), .rd_gnt(rd_gnt),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .start_ssm0(start_ssm0), .start_ssm123(start_ssm123), .starve(starve),
    .busy(busy), .word_cnt(word_cnt), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    ms = 0; q.delete(); m_wc = 0; m_starve = 0; m_s0 = 0; m_s123 = 0; pend = 4'b0000;
  endtask

  task automatic do_cycle(input bit sd, input bit fl, input bit vld, input logic [3:0] req_new);
    logic [3:0]   req;
    logic [3:0]   eg;
    logic [127:0] ed [4];
    logic [127:0] obs_d [4];
    bit           erdy;
    int           taken, n, old_size;
    @(negedge clk);
    req = req_new | pend;
    start_dec = sd; flush = fl; in_vld = vld; rd_req = req;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    eg = 4'b0000; taken = 0; n = 0;
    for (int i = 0; i < 4; i++) begin
      ed[i] = '0;
      if (req[i]) n++;
      if (ms == 2 && !fl && req[i] && taken < q.size()) begin
        eg[i] = 1'b1; ed[i] = q[taken]; taken++;
      end
    end
    erdy = (ms != 0) && !fl && (q.size() < 8);
    #1;
    obs_d[0] = rd_data0; obs_d[1] = rd_data1; obs_d[2] = rd_data2; obs_d[3] = rd_data3;
    check_val("rd_gnt", rd_gnt, eg);
    for (int i = 0; i < 4; i++) check_val($sformatf("rd_data%0d", i), obs_d[i], ed[i]);
    check_val("in_rdy", in_rdy, erdy);
    check_val("level", level, q.size());
    check_val("busy", busy, ms != 0);
    check_val("word_cnt", word_cnt, m_wc);
    check_val("starve", starve, m_starve);
    check_val("start_ssm0", start_ssm0, m_s0);
    check_val("start_ssm123", start_ssm123, m_s123);
    // advance the model to what the next clock edge should produce
    old_size = q.size();
    m_s123 = m_s0 && !fl;
    m_s0 = 0;
    if (ms == 0) begin
      m_starve = 0;
      if (sd) begin ms = 1; m_wc = 0; q.delete(); end
    end else if (fl) begin
      ms = 0; q.delete(); m_starve = 0;
    end else begin
      for (int i = 0; i < taken; i++) void'(q.pop_front());
      if (vld && erdy) q.push_back(in_data);
      m_wc = (m_wc + taken > 65535) ? 65535 : m_wc + taken;
      m_starve = (ms == 2) && (taken < n);
      if (ms == 1 && old_size >= 4) begin ms = 2; m_s0 = 1; end
    end
    pend = fl ? 4'b0000 : (req & ~eg);
  endtask

  initial begin
    rstn = 1'b0; start_dec = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; rd_req = 4'b0000;
    model_clear();
    #12 rstn = 1'b1;
    do_cycle(0, 0, 0, 4'b0000);
    // prefill with 8 back-to-back words, then parallel, sparse and starving reads
    do_cycle(1, 0, 0, 4'b0000);
    for (int i = 0; i < 12; i++) do_cycle(0, 0, 1, 4'b0000);
    do_cycle(0, 0, 0, 4'b1111);
    do_cycle(0, 0, 0, 4'b1010);
    do_cycle(0, 0, 0, 4'b1111);
    do_cycle(0, 0, 0, 4'b0000);
    do_cycle(0, 0, 1, 4'b0000);
    do_cycle(0, 0, 1, 4'b0000);
    do_cycle(0, 0, 0, 4'b0000);
    // fill to five words in RUN, flush, then restart
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 1, 4'b0000);
    do_cycle(0, 0, 0, 4'b0000);
    do_cycle(0, 1, 0, 4'b0011);
    do_cycle(0, 0, 1, 4'b0001);
    do_cycle(1, 0, 1, 4'b0000);
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, 4'b0000);
    // randomized traffic with occasional slice restarts
    for (int c = 0; c < 4000; c++) begin
      bit sd, fl, vld;
      logic [3:0] rq;
      sd  = ($urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 149) == 0);
      vld = ($urandom_range(0, 9) < 7);
      rq  = 4'($urandom) & 4'($urandom);
      do_cycle(sd, fl, vld, rq);
    end
    // asynchronous reset in the middle of FILL
    do_cycle(0, 1, 0, 4'b0000);
    do_cycle(1, 0, 1, 4'b0000);
    do_cycle(0, 0, 1, 4'b0000);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_level", level, 4'd0);
    check_val("rst_in_rdy", in_rdy, 1'b0);
    check_val("rst_word_cnt", word_cnt, 16'd0);
    check_val("rst_pulses", {start_ssm0, start_ssm123, starve}, 3'b000);
    check_val("rst_gnt", rd_gnt, 4'b0000);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 4'b0001);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
